// File: rtl/mem_access_pkg.sv
// ============================================================================
// mem_access_pkg : shared memory-op codes and MEM-stage FSM encodings
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_access_pkg;

   localparam logic [7:0] MEM_NOP = 8'h00;
   localparam logic [7:0] MEM_LB  = 8'h20;
   localparam logic [7:0] MEM_LW  = 8'h23;
   localparam logic [7:0] MEM_SB  = 8'h28;
   localparam logic [7:0] MEM_SW  = 8'h2B;

   localparam logic [1:0] MA_IDLE   = 2'd0;
   localparam logic [1:0] MA_ACCESS = 2'd1;
   localparam logic [1:0] MA_DONE   = 2'd2;

   function automatic logic word_misaligned(input logic [7:0] op, input logic [1:0] lo);
      return ((op == MEM_LW) || (op == MEM_SW)) && (lo != 2'b00);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane.sv
// ============================================================================
// mem_lane : byte-lane steering for SRAM stores and load extraction
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_lane (
   input  logic        i_byte,
   input  logic [1:0]  i_lane,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_load_word,
   output logic [3:0]  o_be_n,
   output logic [31:0] o_store_word,
   output logic [31:0] o_load_data
);

   logic [7:0] w_load_byte;

   always_comb begin
      o_be_n       = 4'h0;
      o_store_word = i_store_data;
      if (i_byte) begin
         o_be_n       = ~(4'b0001 << i_lane);
         o_store_word = {4{i_store_data[7:0]}};
      end
   end

   always_comb begin
      case (i_lane)
         2'd0:    w_load_byte = i_load_word[7:0];
         2'd1:    w_load_byte = i_load_word[15:8];
         2'd2:    w_load_byte = i_load_word[23:16];
         default: w_load_byte = i_load_word[31:24];
      endcase
      o_load_data = i_byte ? {{24{w_load_byte[7]}}, w_load_byte} : i_load_word;
   end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// mem_access : MEM stage driving a fixed-latency asynchronous SRAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access
   import mem_access_pkg::*;
#(
   parameter int ADDR_W      = 20,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        mem_op_i,
   input  logic [31:0]       mem_addr_i,
   input  logic [31:0]       mem_data_i,
   input  logic [31:0]       wdata_i,
   input  logic [4:0]        waddr_i,
   input  logic              we_i,
   output logic              stall_req_o,
   output logic              misalign_o,
   output logic [31:0]       wb_wdata_o,
   output logic [4:0]        wb_waddr_o,
   output logic              wb_we_o,
   output logic [ADDR_W-1:0] sram_addr_o,
   output logic [31:0]       sram_data_o,
   output logic              sram_data_oe_o,
   input  logic [31:0]       sram_data_i,
   output logic              sram_ce_n_o,
   output logic              sram_oe_n_o,
   output logic              sram_we_n_o,
   output logic [3:0]        sram_be_n_o
);

   localparam int                 c_cnt_w = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WAIT_CYCLES - 1);

   logic [1:0]         r_state;
   logic [1:0]         w_next_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [31:0]        r_rdata;
   logic               w_is_load;
   logic               w_is_store;
   logic               w_misalign;
   logic               w_start;
   logic [3:0]         w_be_n;
   logic [31:0]        w_store_word;
   logic [31:0]        w_load_data;
   logic               w_unused_addr;

   assign w_is_load     = (mem_op_i == MEM_LB) || (mem_op_i == MEM_LW);
   assign w_is_store    = (mem_op_i == MEM_SB) || (mem_op_i == MEM_SW);
   assign w_misalign    = word_misaligned(mem_op_i, mem_addr_i[1:0]);
   assign w_start       = (r_state == MA_IDLE) && (w_is_load || w_is_store) && !w_misalign;
   assign w_unused_addr = ^mem_addr_i[31:ADDR_W+2];

   mem_lane u_lane (
      .i_byte       ((mem_op_i == MEM_LB) || (mem_op_i == MEM_SB)),
      .i_lane       (mem_addr_i[1:0]),
      .i_store_data (mem_data_i),
      .i_load_word  (r_rdata),
      .o_be_n       (w_be_n),
      .o_store_word (w_store_word),
      .o_load_data  (w_load_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= MA_IDLE;
      else      r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         MA_IDLE:   if (w_start) w_next_state = MA_ACCESS;
         MA_ACCESS: if (r_cnt == c_last) w_next_state = MA_DONE;
         MA_DONE:   w_next_state = MA_IDLE;
         default:   w_next_state = MA_IDLE;
      endcase
   end

   always_comb begin
      stall_req_o = 1'b0;
      case (r_state)
         MA_IDLE:   stall_req_o = w_start;
         MA_ACCESS: stall_req_o = 1'b1;
         default:   stall_req_o = 1'b0;
      endcase
   end

   // Upstream holds the request stable while stalled, so strobes can be
   // recomputed from the live inputs for every cycle spent in ACCESS.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt          <= '0;
         r_rdata        <= 32'h0;
         misalign_o     <= 1'b0;
         sram_addr_o    <= '0;
         sram_data_o    <= 32'h0;
         sram_data_oe_o <= 1'b0;
         sram_ce_n_o    <= 1'b1;
         sram_oe_n_o    <= 1'b1;
         sram_we_n_o    <= 1'b1;
         sram_be_n_o    <= 4'hF;
      end else begin
         misalign_o <= (r_state == MA_IDLE) && w_misalign;
         if (r_state == MA_ACCESS) begin
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
            if (r_cnt == c_last) r_rdata <= sram_data_i;
         end
         if (w_start) begin
            sram_addr_o <= mem_addr_i[ADDR_W+1:2];
            sram_data_o <= w_store_word;
         end
         if (w_next_state == MA_ACCESS) begin
            sram_ce_n_o    <= 1'b0;
            sram_oe_n_o    <= !w_is_load;
            sram_we_n_o    <= !w_is_store;
            sram_be_n_o    <= w_is_load ? 4'h0 : w_be_n;
            sram_data_oe_o <= w_is_store;
         end else begin
            sram_ce_n_o    <= 1'b1;
            sram_oe_n_o    <= 1'b1;
            sram_we_n_o    <= 1'b1;
            sram_be_n_o    <= 4'hF;
            sram_data_oe_o <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_wdata_o <= 32'h0;
         wb_waddr_o <= 5'd0;
         wb_we_o    <= 1'b0;
      end else if (!stall_req_o) begin
         wb_waddr_o <= waddr_i;
         if (r_state == MA_DONE) begin
            wb_wdata_o <= w_is_load ? w_load_data : wdata_i;
            wb_we_o    <= we_i;
         end else begin
            wb_wdata_o <= wdata_i;
            wb_we_o    <= we_i && !w_misalign;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// tb_mem_access : scoreboard bench for mem_access with a behavioural SRAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_access;
   import mem_access_pkg::*;

   localparam int ADDR_W = 20;
   localparam int WAIT   = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [7:0]        mem_op = MEM_NOP;
   logic [31:0]       mem_addr = 32'h0;
   logic [31:0]       mem_data = 32'h0;
   logic [31:0]       wdata = 32'h0;
   logic [4:0]        waddr = 5'd0;
   logic              we = 1'b0;
   logic              stall_req_o, misalign_o, wb_we_o;
   logic [31:0]       wb_wdata_o, sram_data_o, sram_data_i;
   logic [4:0]        wb_waddr_o;
   logic [ADDR_W-1:0] sram_addr_o;
   logic              sram_data_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
   logic [3:0]        sram_be_n_o;

   logic [31:0] sram [0:15];
   logic [37:0] wb_q[$];
   logic [67:0] sr_q[$];
   int          checks = 0;
   int          errors = 0;
   int          ce_low_total = 0;
   int          mis_total = 0;

   always #5 clk = ~clk;

   mem_access #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT)) dut (
      .clk(clk), .rst(rst),
      .mem_op_i(mem_op), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
      .wdata_i(wdata), .waddr_i(waddr), .we_i(we),
      .stall_req_o(stall_req_o), .misalign_o(misalign_o),
      .wb_wdata_o(wb_wdata_o), .wb_waddr_o(wb_waddr_o), .wb_we_o(wb_we_o),
      .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o),
      .sram_data_oe_o(sram_data_oe_o), .sram_data_i(sram_data_i),
      .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
      .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o)
   );

   assign sram_data_i = (!sram_ce_n_o && !sram_oe_n_o) ? sram[sram_addr_o[3:0]] : 32'h0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [67:0] srec(input logic [19:0] a, input logic [3:0] be,
                                        input logic wen, input logic oen, input logic oe,
                                        input logic [31:0] d);
      return {a, be, wen, oen, oe, d, 8'(WAIT), 1'b1};
   endfunction

   // Behavioural SRAM: preload, then byte writes while strobes are low.
   initial begin
      for (int i = 0; i < 16; i++) sram[i] = 32'h0;
      sram[4] = 32'hDEADBEEF;
      sram[1] = 32'h11223344;
      forever begin
         @(negedge clk);
         if (rst && !sram_ce_n_o && !sram_we_n_o && sram_data_oe_o)
            for (int b = 0; b < 4; b++)
               if (!sram_be_n_o[b]) sram[sram_addr_o[3:0]][8*b +: 8] = sram_data_o[8*b +: 8];
      end
   end

   // WB monitor: a non-stalled cycle commits one result visible one cycle later.
   initial begin
      bit pend = 1'b0;
      forever begin
         @(negedge clk);
         if (pend) chk("wb_result", 128'({wb_wdata_o, wb_waddr_o, wb_we_o}), 128'(wb_q.pop_front()));
         pend = rst && !stall_req_o && (wb_q.size() != 0);
      end
   end

   // SRAM monitor: captures each strobe window and scores it on close.
   initial begin
      bit          in_win = 1'b0;
      bit          stable = 1'b1;
      int          len = 0;
      logic [59:0] snap = '0;
      logic [59:0] now;
      logic [67:0] exp;
      forever begin
         @(negedge clk);
         now = {sram_addr_o, sram_be_n_o, sram_we_n_o, sram_oe_n_o, sram_data_oe_o,
                sram_data_oe_o ? sram_data_o : 32'h0};
         if (!rst) begin
            in_win = 1'b0;
         end else if (!sram_ce_n_o) begin
            ce_low_total++;
            if (!in_win) begin
               in_win = 1'b1; len = 0; stable = 1'b1; snap = now;
            end else if (now !== snap) begin
               stable = 1'b0;
            end
            len++;
         end else if (in_win) begin
            in_win = 1'b0;
            exp = (sr_q.size() != 0) ? sr_q.pop_front() : 68'h0;
            chk("sram_access", 128'({snap, 8'(len), stable}), 128'(exp));
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst && misalign_o) mis_total++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] wd, input logic [4:0] wa, input logic w,
                        input logic [31:0] exp_wd, input logic exp_we, input int exp_stall);
      int n;
      mem_op = op; mem_addr = addr; mem_data = data; wdata = wd; waddr = wa; we = w;
      wb_q.push_back({exp_wd, wa, exp_we});
      n = 0;
      @(negedge clk);
      while (stall_req_o && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("stall_cycles", 128'(n), 128'(exp_stall));
      @(posedge clk); #1;
   endtask

   initial begin
      int ce_before;
      @(negedge clk);
      chk("reset_wb", 128'({wb_wdata_o, wb_waddr_o, wb_we_o}), 128'h0);
      chk("reset_strobes", 128'({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o, sram_data_oe_o}),
          128'({3'b111, 4'hF, 1'b0}));
      chk("reset_addr_data", 128'({sram_addr_o, sram_data_o}), 128'h0);
      chk("reset_misalign_stall", 128'({misalign_o, stall_req_o}), 128'h0);
      #2 rst = 1'b1;
      @(posedge clk); #1;

      // ALU result then an immediate load
      issue(MEM_NOP, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 32'h1234, 1'b1, 0);
      sr_q.push_back(srec(20'd4, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0));
      issue(MEM_LW, 32'h10, 32'h0, 32'hAAAA, 5'd7, 1'b1, 32'hDEADBEEF, 1'b1, WAIT + 1);
      sr_q.push_back(srec(20'd4, 4'h0, 1'b0, 1'b1, 1'b1, 32'h80FF0000));
      issue(MEM_SW, 32'h10, 32'h80FF0000, 32'hCAFE, 5'd3, 1'b0, 32'hCAFE, 1'b0, WAIT + 1);
      sr_q.push_back(srec(20'd4, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0));
      issue(MEM_LB, 32'h13, 32'h0, 32'h0, 5'd8, 1'b1, 32'hFFFFFF80, 1'b1, WAIT + 1);
      sr_q.push_back(srec(20'd4, 4'h7, 1'b0, 1'b1, 1'b1, 32'h7F7F7F7F));
      issue(MEM_SB, 32'h13, 32'hFFFFFF7F, 32'hCAFE, 5'd3, 1'b0, 32'hCAFE, 1'b0, WAIT + 1);
      sr_q.push_back(srec(20'd4, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0));
      issue(MEM_LB, 32'h13, 32'h0, 32'h0, 5'd8, 1'b1, 32'h0000007F, 1'b1, WAIT + 1);
      sr_q.push_back(srec(20'd1, 4'hB, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5));
      issue(MEM_SB, 32'h06, 32'h000000A5, 32'hBEEF, 5'd2, 1'b0, 32'hBEEF, 1'b0, WAIT + 1);
      sr_q.push_back(srec(20'd1, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0));
      issue(MEM_LW, 32'h04, 32'h0, 32'h0, 5'd9, 1'b1, 32'h11A53344, 1'b1, WAIT + 1);
      sr_q.push_back(srec(20'd1, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0));
      issue(MEM_LB, 32'h06, 32'h0, 32'h0, 5'd10, 1'b1, 32'hFFFFFFA5, 1'b1, WAIT + 1);
      sr_q.push_back(srec(20'd1, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0));
      issue(MEM_LB, 32'h04, 32'h0, 32'h0, 5'd11, 1'b1, 32'h00000044, 1'b1, WAIT + 1);

      // misaligned word accesses: no SRAM window, no stall, write enable dropped
      ce_before = ce_low_total;
      issue(MEM_SW, 32'h02, 32'h99, 32'h55, 5'd4, 1'b1, 32'h55, 1'b0, 0);
      issue(MEM_LW, 32'h11, 32'h0, 32'h66, 5'd6, 1'b1, 32'h66, 1'b0, 0);
      mem_op = MEM_NOP; we = 1'b0;
      @(negedge clk);
      chk("misalign_pulse", 128'(misalign_o), 128'h1);
      @(negedge clk);
      chk("misalign_clear", 128'(misalign_o), 128'h0);
      chk("misalign_no_strobe", 128'(ce_low_total - ce_before), 128'h0);
      @(posedge clk); #1;

      // reset asserted in the second ACCESS cycle of a store
      mem_op = MEM_SW; mem_addr = 32'h08; mem_data = 32'hFFFF0000; wdata = 32'h0; waddr = 5'd1; we = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      chk("store_in_access", 128'({sram_ce_n_o, sram_we_n_o, stall_req_o}), 128'({1'b0, 1'b0, 1'b1}));
      #1 rst = 1'b0; mem_op = MEM_NOP;
      #1;
      chk("abort_strobes", 128'({sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o, sram_data_oe_o}),
          128'({3'b111, 4'hF, 1'b0}));
      chk("abort_wb", 128'({wb_wdata_o, wb_waddr_o, wb_we_o}), 128'h0);
      chk("abort_addr_data", 128'({sram_addr_o, sram_data_o}), 128'h0);
      @(negedge clk);
      @(posedge clk); #3 rst = 1'b1;
      @(negedge clk);
      chk("stall_after_release", 128'(stall_req_o), 128'h0);
      @(posedge clk); #1;
      sr_q.push_back(srec(20'd4, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0));
      issue(MEM_LW, 32'h10, 32'h0, 32'h0, 5'd12, 1'b1, 32'h7FFF0000, 1'b1, WAIT + 1);

      mem_op = MEM_NOP; we = 1'b0;
      repeat (4) @(negedge clk);
      chk("wb_queue_drained", 128'(wb_q.size()), 128'h0);
      chk("sram_queue_drained", 128'(sr_q.size()), 128'h0);
      chk("misalign_pulse_total", 128'(mis_total), 128'h2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM-stage responder for the load/store requests the EX stage issues as mem_op/mem_addr/mem_data.
- Drives a single-port asynchronous external SRAM with a fixed multi-cycle access.
- Stalls the pipeline while an access is in flight.
- Registers the writeback result (ALU data or load data) into the MEM/WB boundary.

Parameters:
- ADDR_W, 20, SRAM word-address width; the SRAM word address is mem_addr_i[ADDR_W+1:2].
- WAIT_CYCLES, 2, number of cycles the SRAM control strobes are held per access (minimum 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_op_i  in  8  MEM_NOP / MEM_LB / MEM_LW / MEM_SB / MEM_SW.
- mem_addr_i  in  32  byte address.
- mem_data_i  in  32  store data; SB uses bits [7:0].
- wdata_i  in  32  ALU result from EX.
- waddr_i  in  5  destination register.
- we_i  in  1  register write enable.
- stall_req_o  out  1  hold upstream stages and inputs stable.
- misalign_o  out  1  one-cycle pulse on a misaligned LW/SW.
- wb_wdata_o  out  32  registered writeback data.
- wb_waddr_o  out  5  registered destination register.
- wb_we_o  out  1  registered write enable.
- sram_addr_o  out  ADDR_W  word address.
- sram_data_o  out  32  write data.
- sram_data_oe_o  out  1  data bus drive enable.
- sram_data_i  in  32  read data.
- sram_ce_n_o  out  1  chip enable, active low.
- sram_oe_n_o  out  1  output enable, active low.
- sram_we_n_o  out  1  write enable, active low.
- sram_be_n_o  out  4  byte enables, active low.

Behaviour:
- Reset state (rst low, asynchronous):
  - FSM goes to IDLE, counter is 0, misalign_o is 0.
  - wb_wdata_o = 0, wb_waddr_o = 0, wb_we_o = 0.
  - All SRAM strobes are high, sram_be_n_o = 4'hF, sram_data_oe_o = 0, sram_addr_o = 0, sram_data_o = 0.
  - Reset mid-access aborts immediately; there are no partial writeback side effects.
- Request: mem_op_i != MEM_NOP while in IDLE.
- Misaligned: LW or SW with mem_addr_i[1:0] != 0.
  - No SRAM access; misalign_o pulses for 1 cycle.
  - The request is treated as a NOP with we forced to 0.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE -> ACCESS on an aligned request.
  - ACCESS: counter runs 0..WAIT_CYCLES-1; leaves to DONE when counter = WAIT_CYCLES-1.
  - DONE -> IDLE unconditionally.
- stall_req_o is combinational:
  - 1 in IDLE when an aligned request is present.
  - 1 in every ACCESS cycle.
  - 0 in DONE.
  - Upstream therefore advances on the DONE cycle.
- SRAM timing: strobes are registered and asserted on entry to ACCESS, held through all ACCESS cycles, and deasserted in DONE. Address and data are stable for the whole window.
- Loads: ce_n = 0, oe_n = 0, be_n = 4'h0, oe = 0. sram_data_i is captured on the last ACCESS cycle.
- Stores:
  - ce_n = 0, we_n = 0, oe = 1.
  - SW: be_n = 4'h0, data = mem_data_i.
  - SB: byte replicated on all 4 lanes; be_n clears only bit addr[1:0] (e.g. addr[1:0] = 2 gives 4'hB).
- Load extraction:
  - LW: full word.
  - LB: lane addr[1:0] (lane 0 = bits [7:0]), sign-extended to 32 bits.
- WB register updates whenever stall_req_o = 0:
  - Loads in DONE: wdata = extracted load data; waddr/we taken from the held inputs.
  - Stores in DONE: waddr/we from inputs; wdata = wdata_i.
  - NOP or misaligned in IDLE: wdata_i/waddr_i/we_i (we = 0 if misaligned).
  - While stalled, WB outputs hold their value.
- Latency: aligned access occupies WAIT_CYCLES+1 stall cycles. The WB result is visible the cycle after DONE.
- Back-to-back requests: a new request presented on the cycle after DONE is accepted from IDLE with no bubble beyond the DONE cycle.

Decomposition:
- Shared include:
  - MEM_NOP/LB/LW/SB/SW codes (already owned by the EX stage).
  - FSM state encodings MA_IDLE/MA_ACCESS/MA_DONE.
- One sub-module, mem_lane: purely combinational.
  - Store side: byte-enable and lane replication.
  - Load side: lane select and sign-extension.
- The FSM, counter, SRAM registers and WB register stay in mem_access.

Test Plan:
- LW at 0x0000_0010, SRAM word 4 = 0xDEADBEEF, WAIT_CYCLES = 2 -> sram_addr = 4, oe_n low for 2 cycles, stall_req high 3 cycles, wb_wdata = 0xDEADBEEF with wb_we = 1.
- LB at 0x0000_0013, word = 0x80FF_0000 -> lane 3 = 0x80, wb_wdata = 0xFFFF_FF80. Same with byte 0x7F -> 0x0000_007F.
- SB at 0x0000_0006 with data 0x0000_00A5 -> be_n = 4'hB, sram_data = 0xA5A5A5A5, we_n low 2 cycles. Readback of the word changes only byte 2.
- SW at 0x0000_0002 -> misalign_o pulses 1 cycle, no strobe ever low, stall_req stays 0, wb_we = 0.
- rst pulled low during the second ACCESS cycle of an SW -> strobes high immediately, wb outputs 0, FSM restarts in IDLE, no stall after release.
- ALU op (NOP) with wdata 0x1234 to r5, followed immediately by an LW -> WB shows 0x1234/r5 first, then the load result after WAIT_CYCLES+1 stall cycles.
